// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared SPI definitions for the register read and write paths.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_REG_WIDTH = 8;
    localparam int SPI_MAX_REGS  = 255;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_ADDR = 3'd1,
        ST_SEND_DATA = 3'd2,
        ST_STALL     = 3'd3,
        ST_COMPLETE  = 3'd4
    } spi_write_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_cmd_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_edge_detect
// Description : Registered rising-edge detector for the command strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_edge_detect (
    input  logic clk,
    input  logic rstn,
    input  logic cmd,
    output logic rise
);

    logic r_prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= cmd;
        end
    end

    assign rise = cmd & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_write.sv
`default_nettype none
// ============================================================================
// Module      : spi_write
// Description : SPI write initiator: address word then N FIFO data words, MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_write
    import spi_pkg::*;
#(
    parameter int REG_WIDTH = SPI_REG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 new_command,
    input  logic                 is_write,
    input  logic [7:0]           num_regs_to_write,
    input  logic [REG_WIDTH-1:0] start_write_register_addr,
    input  logic [REG_WIDTH-1:0] fifo_dout,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic                 serial_out,
    output logic                 spi_clk,
    output logic                 busy,
    output logic                 write_one_byte_complete,
    output logic                 write_complete
);

    localparam int                 c_IDX_W   = $clog2(REG_WIDTH);
    localparam logic [c_IDX_W-1:0] c_MSB_IDX = c_IDX_W'(REG_WIDTH - 1);

    spi_write_state_t       r_state;
    spi_write_state_t       w_next_state;
    logic [REG_WIDTH-1:0]   r_shift;
    logic [7:0]             r_remaining;
    logic [c_IDX_W-1:0]     r_bit_idx;
    logic                   r_sclk_en;
    logic                   r_sout;
    logic                   r_byte_done;
    logic                   w_cmd_rise;
    logic                   w_start;
    logic                   w_word_end;
    logic                   w_words_left;

    spi_cmd_edge_detect u_cmd_edge (
        .clk  (clk),
        .rstn (rstn),
        .cmd  (new_command),
        .rise (w_cmd_rise)
    );

    assign w_start      = w_cmd_rise & is_write & (r_state == ST_IDLE);
    // Bit 0 of the current word is on the wire this cycle.
    assign w_word_end   = r_sclk_en & (r_bit_idx == '0) &
                          ((r_state == ST_SEND_ADDR) | (r_state == ST_SEND_DATA));
    assign w_words_left = (r_remaining != 8'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next_state = ST_SEND_ADDR;
                end
            end
            ST_SEND_ADDR, ST_SEND_DATA: begin
                if (w_word_end) begin
                    if (!w_words_left) begin
                        w_next_state = ST_COMPLETE;
                    end else if (fifo_empty) begin
                        w_next_state = ST_STALL;
                    end else begin
                        w_next_state = ST_SEND_DATA;
                    end
                end
            end
            ST_STALL: begin
                if (!fifo_empty) begin
                    w_next_state = ST_SEND_DATA;
                end
            end
            ST_COMPLETE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        fifo_rd_en     = 1'b0;
        busy           = (r_state != ST_IDLE);
        write_complete = (r_state == ST_COMPLETE);
        if (w_word_end && w_words_left && !fifo_empty) begin
            fifo_rd_en = 1'b1;
        end
        if ((r_state == ST_STALL) && !fifo_empty) begin
            fifo_rd_en = 1'b1;
        end
    end

    // A popped word goes straight to the wire so data follows address with no gap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shift     <= '0;
            r_remaining <= 8'd0;
            r_bit_idx   <= '0;
            r_sclk_en   <= 1'b0;
            r_sout      <= 1'b0;
            r_byte_done <= 1'b0;
        end else begin
            r_byte_done <= (r_state == ST_SEND_DATA) & w_word_end;
            if (w_start) begin
                r_shift     <= start_write_register_addr;
                r_remaining <= num_regs_to_write;
                r_bit_idx   <= c_MSB_IDX;
                r_sclk_en   <= 1'b0;
                r_sout      <= 1'b0;
            end else if (fifo_rd_en) begin
                r_sout      <= fifo_dout[REG_WIDTH-1];
                r_shift     <= {fifo_dout[REG_WIDTH-2:0], 1'b0};
                r_remaining <= r_remaining - 8'd1;
                r_bit_idx   <= c_MSB_IDX;
                r_sclk_en   <= 1'b1;
            end else if ((r_state == ST_SEND_ADDR) && !r_sclk_en) begin
                r_sout    <= r_shift[REG_WIDTH-1];
                r_shift   <= {r_shift[REG_WIDTH-2:0], 1'b0};
                r_sclk_en <= 1'b1;
            end else if (w_word_end) begin
                r_sout    <= 1'b0;
                r_sclk_en <= 1'b0;
            end else if (r_sclk_en) begin
                r_sout    <= r_shift[REG_WIDTH-1];
                r_shift   <= {r_shift[REG_WIDTH-2:0], 1'b0};
                r_bit_idx <= r_bit_idx - c_IDX_W'(1);
            end
        end
    end

    assign spi_clk                 = r_sclk_en & ~clk & rstn;
    assign serial_out              = r_sout;
    assign write_one_byte_complete = r_byte_done;

endmodule
`default_nettype wire

// File: tb/tb_spi_write.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_write
// Description : Self-checking bench for spi_write using directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_write;

    logic       clk = 1'b0;
    logic       rstn;
    logic       new_command;
    logic       is_write;
    logic [7:0] num_regs_to_write;
    logic [7:0] start_write_register_addr;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic       serial_out;
    logic       spi_clk;
    logic       busy;
    logic       write_one_byte_complete;
    logic       write_complete;

    always #5 clk = ~clk;

    spi_write #(.REG_WIDTH(8)) dut (
        .clk                       (clk),
        .rstn                      (rstn),
        .new_command               (new_command),
        .is_write                  (is_write),
        .num_regs_to_write         (num_regs_to_write),
        .start_write_register_addr (start_write_register_addr),
        .fifo_dout                 (fifo_dout),
        .fifo_empty                (fifo_empty),
        .fifo_rd_en                (fifo_rd_en),
        .serial_out                (serial_out),
        .spi_clk                   (spi_clk),
        .busy                      (busy),
        .write_one_byte_complete   (write_one_byte_complete),
        .write_complete            (write_complete)
    );

    typedef struct {
        logic [7:0]  addr;
        int          n;
        logic [7:0]  w0;
        logic [7:0]  w1;
        logic [7:0]  w2;
        int          preload;
        int          late;
        int          glitch;
        logic [31:0] exp_bits;
        int          exp_nbits;
        int          exp_last;
        int          exp_wc;
        int          exp_quiet;
        int          exp_pop1;
    } vec_t;

    vec_t vecs[5];

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0]  q[$];
    int          cyc, nbits, first_bit, last_bit, pops, pop1, byte_done;
    int          wc_n, wc_cyc, quiet, quiet_sout, empty_pop, post_busy, late_cnt;
    logic [31:0] bits;
    logic        rd, late_pending, in_post;
    logic [7:0]  late_w;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fifo_refresh();
        fifo_empty = (q.size() == 0);
        fifo_dout  = (q.size() == 0) ? 8'h00 : q[0];
    endtask

    task automatic clear_mon();
        cyc = -1; nbits = 0; first_bit = -1; last_bit = -1; pops = 0; pop1 = -1;
        byte_done = 0; wc_n = 0; wc_cyc = -1; quiet = 0; quiet_sout = 0;
        empty_pop = 0; post_busy = 0; late_cnt = 0; bits = 32'h0;
        late_pending = 1'b0; in_post = 1'b0; late_w = 8'h00; rd = 1'b0;
    endtask

    // One clock: observe mid-cycle (spi_clk rising), then update the FIFO model after the edge.
    task automatic tick();
        @(negedge clk); #1;
        rd = fifo_rd_en;
        if (in_post && busy) post_busy++;
        if (spi_clk) begin
            bits = {bits[30:0], serial_out};
            nbits++;
            if (first_bit < 0) first_bit = cyc;
            last_bit = cyc;
        end else if (busy) begin
            quiet++;
            if (serial_out) quiet_sout++;
        end
        if (rd) begin
            if (fifo_empty) empty_pop++;
            if (pops == 0) pop1 = nbits;
            pops++;
        end
        if (write_one_byte_complete) begin
            byte_done++;
            if (late_pending) begin
                late_pending = 1'b0;
                late_cnt = 5;
            end
        end
        if (write_complete) begin
            wc_n++;
            wc_cyc = cyc;
        end
        @(posedge clk); #1;
        cyc++;
        if (rd && q.size() > 0) q.delete(0);
        if (late_cnt > 0) begin
            late_cnt--;
            if (late_cnt == 0) q.push_back(late_w);
        end
        fifo_refresh();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        q.delete();
        if (v.preload > 0) q.push_back(v.w0);
        if (v.preload > 1) q.push_back(v.w1);
        if (v.preload > 2) q.push_back(v.w2);
        fifo_refresh();
        start_write_register_addr = v.addr;
        num_regs_to_write = 8'(v.n);
        is_write = 1'b1;
        new_command = 1'b0;
        tick();
        clear_mon();
        if (v.late != 0) begin
            late_pending = 1'b1;
            late_w = v.w1;
        end
        new_command = 1'b1;
        for (int k = 0; k < 400 && wc_n == 0; k++) begin
            tick();
            if (v.glitch >= 0 && cyc == v.glitch) new_command = 1'b0;
            if (v.glitch >= 0 && cyc == v.glitch + 2) new_command = 1'b1;
        end
        in_post = 1'b1;
        repeat (10) tick();
        in_post = 1'b0;
        new_command = 1'b0;
        check($sformatf("v%0d bit count", idx), nbits, v.exp_nbits);
        check($sformatf("v%0d bitstream", idx), bits, v.exp_bits);
        check($sformatf("v%0d first bit edge", idx), first_bit, 1);
        check($sformatf("v%0d last bit edge", idx), last_bit, v.exp_last);
        check($sformatf("v%0d pops", idx), pops, v.n);
        check($sformatf("v%0d first pop position", idx), pop1, v.exp_pop1);
        check($sformatf("v%0d byte done pulses", idx), byte_done, v.n);
        check($sformatf("v%0d complete pulses", idx), wc_n, 1);
        check($sformatf("v%0d complete cycle", idx), wc_cyc, v.exp_wc);
        check($sformatf("v%0d gated busy cycles", idx), quiet, v.exp_quiet);
        check($sformatf("v%0d mosi while gated", idx), quiet_sout, 0);
        check($sformatf("v%0d pop while empty", idx), empty_pop, 0);
        check($sformatf("v%0d retrigger busy", idx), post_busy, 0);
    endtask

    initial begin
        //           addr   n  w0     w1     w2     pre late glitch exp_bits         nb  last wc quiet pop1
        vecs[0] = '{8'hA5, 1, 8'h3C, 8'h00, 8'h00, 1, 0, -1, 32'h0000A53C, 16, 16, 17, 2, 8};
        vecs[1] = '{8'h10, 3, 8'h01, 8'h80, 8'hFF, 3, 0, 10, 32'h100180FF, 32, 32, 33, 2, 8};
        vecs[2] = '{8'h81, 2, 8'h5A, 8'hC3, 8'h00, 1, 1, -1, 32'h00815AC3, 24, 30, 31, 8, 8};
        vecs[3] = '{8'h7F, 0, 8'h00, 8'h00, 8'h00, 0, 0, -1, 32'h0000007F,  8,  8,  9, 2, -1};
        vecs[4] = '{8'h5C, 1, 8'h96, 8'h00, 8'h00, 1, 0, -1, 32'h00005C96, 16, 16, 17, 2, 8};

        clear_mon();
        q.delete();
        fifo_refresh();
        rstn = 1'b0;
        new_command = 1'b0;
        is_write = 1'b0;
        num_regs_to_write = 8'h00;
        start_write_register_addr = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset outputs", {spi_clk, serial_out, busy, fifo_rd_en,
                                write_one_byte_complete, write_complete}, 0);
        rstn = 1'b1;
        repeat (2) tick();

        // A read command edge must leave the write path idle.
        clear_mon();
        is_write = 1'b0;
        new_command = 1'b1;
        in_post = 1'b1;
        repeat (6) tick();
        in_post = 1'b0;
        new_command = 1'b0;
        tick();
        check("read cmd busy", post_busy, 0);
        check("read cmd bits", nbits, 0);

        for (int i = 0; i < 4; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset in the middle of the first data word.
        q.delete();
        q.push_back(8'h18);
        q.push_back(8'h22);
        fifo_refresh();
        start_write_register_addr = 8'hC3;
        num_regs_to_write = 8'd2;
        is_write = 1'b1;
        new_command = 1'b0;
        tick();
        clear_mon();
        new_command = 1'b1;
        for (int k = 0; k < 100 && nbits < 12; k++) tick();
        check("reset test reached data", nbits, 12);
        @(negedge clk); #1;
        check("5th data bit on wire", {spi_clk, serial_out, busy}, 3'b111);
        rstn = 1'b0;
        #1;
        check("async reset outputs", {spi_clk, serial_out, busy, fifo_rd_en,
                                      write_one_byte_complete, write_complete}, 0);
        new_command = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("idle after reset", busy, 0);
        in_post = 1'b1;
        repeat (6) tick();
        in_post = 1'b0;
        check("no pops after reset", pops, 1);
        check("stays idle after reset", post_busy, 0);

        run_vec(4, vecs[4]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_write.md
Name: spi_write

Overview:
- SPI write initiator; the transmit-direction companion of the SPI register read path on the control board.
- On a rising edge of new_command with is_write=1, it shifts out one start-address word, then num_regs data words, all MSB-first.
- Data words come from a first-word-fall-through (FWFT) TX FIFO. If the FIFO runs dry, the block stalls with the SPI clock gated.
- Shares serial_out and spi_clk with the read path through the top-level mux, selected by is_write.

Parameters:
REG_WIDTH, 8, width of the address word and of each data word (at least 2)

Ports:
clk  input  1  system clock; spi_clk is derived from it
rstn  input  1  reset, asynchronous, active-low
new_command  input  1  command strobe; a rising edge starts a transaction
is_write  input  1  the transaction is a write; sampled together with the new_command edge
num_regs_to_write  input  8  number of data words to send (0 allowed)
start_write_register_addr  input  REG_WIDTH  first register address
fifo_dout  input  REG_WIDTH  TX FIFO head word (FWFT)
fifo_empty  input  1  TX FIFO empty
fifo_rd_en  output  1  pops the TX FIFO head; combinational
serial_out  output  1  MOSI
spi_clk  output  1  gated SPI clock
busy  output  1  high whenever state != IDLE
write_one_byte_complete  output  1  one-cycle pulse after each data word has been fully shifted out
write_complete  output  1  one-cycle pulse at the end of the transaction

Behaviour:
- Reset (asynchronous, rstn=0):
  - state=IDLE; all counters and the shifter cleared; edge-detect register cleared.
  - serial_out, busy, write_one_byte_complete and write_complete all 0.
  - spi_clk forced to 0 immediately (combinationally); fifo_rd_en=0.
  - Reset mid-frame aborts the frame with no further FIFO pops. Words already popped are lost.
- spi_clk = ~clk while the registered spi_clk_en=1, else 0. serial_out changes on the clk rising edge; the peripheral samples on the spi_clk rising edge (mid-bit).
- Trigger:
  - Trigger condition: new_command=1, its registered previous value=0, is_write=1, state=IDLE.
  - Call the edge on which the trigger is detected E. At E, capture the address and num_regs.
  - Edges detected while not IDLE are ignored. A level held high through completion does not retrigger.
- States are IDLE, SEND_ADDR, SEND_DATA, STALL, COMPLETE.
- SEND_ADDR:
  - Address bit REG_WIDTH-1-k is driven from edge E+1+k, with spi_clk_en=1.
  - A 3-bit (clog2 REG_WIDTH) bit index counts down.
- Word boundary (the cycle presenting bit 0 of the address or of a data word):
  - If words remain and fifo_empty=0: fifo_rd_en=1 in that cycle. At the next edge the shifter loads fifo_dout, the remaining count decrements, state=SEND_DATA, and the MSB is driven with no gap.
  - If words remain and fifo_empty=1: next state=STALL.
  - If no words remain: next state=COMPLETE.
- STALL:
  - spi_clk_en=0, serial_out=0.
  - When fifo_empty=0: fifo_rd_en=1 that cycle; the word loads at the next edge and SEND_DATA resumes with spi_clk_en=1.
  - No timeout.
- write_one_byte_complete pulses in the cycle after the edge that ends bit 0 of each data word, including the last one.
- COMPLETE: spi_clk_en=0, serial_out=0, write_complete=1 for one cycle, then IDLE.
- Latency: with no stalls, clocked bits occupy edges E+1 through E+(N+1)*REG_WIDTH, and write_complete is high in the cycle after edge E+(N+1)*REG_WIDTH+1.
- num_regs_to_write=0: address only, then COMPLETE; no FIFO pops.
- The remaining-word counter is 8 bits and cannot wrap (maximum 255 words).
- fifo_rd_en is never asserted while fifo_empty=1, and at most one pop occurs per word.

Decomposition:
- spi_pkg (shared with the read path) holds:
  - spi_write_state_t;
  - the SPI_REG_WIDTH default;
  - the SPI_MAX_REGS constant (255).
- Optional sub-module spi_cmd_edge_detect: registered rising-edge detector for new_command, reused by the read path.
- The shifter, counters and FSM stay inline.

Test Plan:
- Single write: addr=0xA5, N=1, FIFO={0x3C}. serial_out shows bits 10100101 then 00111100, with 16 spi_clk pulses. fifo_rd_en is high exactly once, in the cycle presenting address bit 0. write_one_byte_complete pulses once, and write_complete pulses in the cycle after edge E+17.
- Burst: addr=0x10, N=3, FIFO={0x01,0x80,0xFF} preloaded. 32 contiguous spi_clk pulses, three pops, three byte-complete pulses, and the bitstream matches exactly.
- Underflow stall: N=2, FIFO holds 1 word, with the second pushed 5 cycles after the first word ends. spi_clk is low and serial_out=0 for the stall, then resumes with the correct MSB. The total clocked-bit count is 24.
- Zero length: N=0, addr=0x7F. 8 spi_clk pulses, fifo_rd_en never asserted, write_complete pulses once.
- Filtering:
  - new_command edge with is_write=0 → stays IDLE, busy=0.
  - A second edge during the burst is ignored.
  - new_command held high after completion → no retrigger.
- Reset mid-frame: assert rstn=0 at the 5th data bit. spi_clk and all outputs go to 0 immediately. After release the block is IDLE and a new write completes normally.
